// File: rtl/riscv_muldiv_pkg.sv
// Shared types and operation-class helpers for the riscv_muldiv multiply/divide unit.
// Optional single-cycle multiplier: RISCV_MULDIV_FAST_MUL_EN (see riscv_muldiv.sv).
package riscv_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_a(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/riscv_muldiv_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the difference when it is non-negative.
module riscv_muldiv_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              dividend_bit_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              q_bit_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  // rem_i < divisor_i always holds, so the sign bit of trial is a clean borrow flag.
  assign shifted = {rem_i, dividend_bit_i};
  assign trial   = shifted - {1'b0, divisor_i};
  assign q_bit_o = ~trial[DATA_W];
  assign rem_o   = q_bit_o ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/riscv_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with valid/ready request and result ports.
// Define RISCV_MULDIV_FAST_MUL_EN to replace the iterative multiplier by a combinational one.
module riscv_muldiv
  import riscv_muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [TAG_W-1:0]  tag_out,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid/result/tag_out hold steady until that edge, and flush overrides everything.

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, res_q, res_d;
  logic              neg_q, neg_d, rneg_q, rneg_d;

  muldiv_op_e        in_op;
  logic              a_neg, b_neg, div_zero, div_ovf;
  logic [DATA_W-1:0] a_mag, b_mag, special_res;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W-1:0] div_rem;
  logic              div_qbit;
  logic [2*DATA_W-1:0] prod, prod_s;
  logic [DATA_W-1:0] quo_s, rem_s, fix_res;

  assign in_op    = muldiv_op_e'(funct3);
  assign a_neg    = is_signed_a(in_op) & rs1[DATA_W-1];
  assign b_neg    = is_signed_b(in_op) & rs2[DATA_W-1];
  assign a_mag    = a_neg ? -rs1 : rs1;
  assign b_mag    = b_neg ? -rs2 : rs2;
  assign div_zero = is_div(in_op) && (rs2 == '0);
  assign div_ovf  = ((in_op == OP_DIV) || (in_op == OP_REM)) && (rs1 == MOST_NEG) && (rs2 == '1);

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = ((in_op == OP_REM) || (in_op == OP_REMU)) ? rs1 : '1;
    else if (div_ovf) special_res = (in_op == OP_DIV) ? rs1 : '0;
  end

  // Shift-add: {hi,lo} starts as {0, multiplier}; multiplicand sits in opnd_q.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});

  riscv_muldiv_div_step #(.DATA_W(DATA_W)) u_div_step (
    .rem_i          (hi_q),
    .dividend_bit_i (lo_q[DATA_W-1]),
    .divisor_i      (opnd_q),
    .rem_o          (div_rem),
    .q_bit_o        (div_qbit)
  );

  assign prod   = {hi_q, lo_q};
  assign prod_s = neg_q ? -prod : prod;
  assign quo_s  = neg_q ? -lo_q : lo_q;
  assign rem_s  = rneg_q ? -hi_q : hi_q;

  always_comb begin
    case (op_q)
      OP_MUL:                       fix_res = prod_s[DATA_W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_s[2*DATA_W-1:DATA_W];
      OP_DIV, OP_DIVU:              fix_res = quo_s;
      default:                      fix_res = rem_s;
    endcase
  end

`ifdef RISCV_MULDIV_FAST_MUL_EN
  logic [2*DATA_W-1:0] fast_prod;
  assign fast_prod = {{DATA_W{1'b0}}, a_mag} * {{DATA_W{1'b0}}, b_mag};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      tag_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_d   = in_op;
          tag_d  = tag_in;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = '0;
          if (div_zero || div_ovf) begin
            res_d   = special_res;
            state_d = DONE;
          end else if (is_div(in_op)) begin
            hi_d    = '0;
            lo_d    = a_mag;
            opnd_d  = b_mag;
            state_d = BUSY;
          end else begin
`ifdef RISCV_MULDIV_FAST_MUL_EN
            {hi_d, lo_d} = fast_prod;
            state_d      = FIX;
`else
            hi_d    = '0;
            lo_d    = b_mag;
            opnd_d  = a_mag;
            state_d = BUSY;
`endif
          end
        end
        BUSY: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_div(op_q)) begin
            hi_d = div_rem;
            lo_d = {lo_q[DATA_W-2:0], div_qbit};
          end else begin
            {hi_d, lo_d} = {mul_sum, lo_q[DATA_W-1:1]};
          end
          if (cnt_q == CNT_W'(DATA_W-1)) state_d = FIX;
        end
        FIX: begin
          res_d   = fix_res;
          state_d = DONE;
        end
        default: if (out_ready) state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
    result    = res_q;
    tag_out   = tag_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed bench for riscv_muldiv: arithmetic model, result scoreboard, latency,
// backpressure, flush and asynchronous-reset checks.
module tb_riscv_muldiv;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0]   funct3;
  logic [W-1:0] rs1, rs2, result;
  logic [4:0]   tag_in, tag_out;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [4:0]   exp_tag_q[$];

  riscv_muldiv #(.DATA_W(W), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .tag_in(tag_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .tag_out(tag_out), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  // RISC-V M semantics from 64-bit arithmetic on sign/zero-extended operands.
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa, sb, sq;
    logic [63:0] ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == MIN_NEG && b == '1) return a;
        sq = sa / sb; return sq[31:0];
      end
      3'd5: begin
        if (b == 0) return '1;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == '1) return '0;
        sq = sa % sb; return sq[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic is_d, sgn;
    is_d = (op >= 3'd4);
    sgn  = (op == 3'd4) || (op == 3'd6);
    if (is_d && (b == 0 || (sgn && a == MIN_NEG && b == '1))) return 1;
`ifdef RISCV_MULDIV_FAST_MUL_EN
    if (!is_d) return 2;
`endif
    return W + 2;
  endfunction

  // Scoreboard: every cycle a result is presented it must match the head of exp_q.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid result=%h expected=no_result", result);
      end else begin
        check("result", result, exp_q[0]);
        check("tag_out", 32'(tag_out), 32'(exp_tag_q[0]));
        check("in_ready_while_valid", 32'(in_ready), 32'd0);
        check("busy_while_valid", 32'(busy), 32'd1);
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(exp_tag_q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] tag);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("issue_ready", 32'(in_ready), 32'd1);
    funct3 = op; rs1 = a; rs2 = b; tag_in = tag; in_valid = 1'b1;
    exp_q.push_back(model(op, a, b));
    exp_tag_q.push_back(tag);
    @(posedge clk); #1;
    in_valid = 1'b0;
    funct3 = 3'($urandom_range(0, 7));
    rs1 = $urandom;
    rs2 = $urandom;
    tag_in = 5'($urandom_range(0, 31));
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] tag, input logic [W-1:0] lit, input int hold);
    int lat = 1;
    bit seen = 0;
    check("model_pin", model(op, a, b), lit);
    issue(op, a, b, tag);
    for (int i = 0; i < 200 && !seen; i++) begin
      if (out_valid) seen = 1;
      else begin
        @(posedge clk); #1; lat++;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout actual=never expected=within_200_cycles");
    end else begin
      check("latency", 32'(lat), 32'(model_lat(op, a, b)));
      for (int i = 0; i < hold; i++) begin
        check("bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("retire_out_valid", 32'(out_valid), 32'd0);
      check("retire_in_ready", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    funct3 = '0; rs1 = '0; rs2 = '0; tag_in = '0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_tag", 32'(tag_out), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 32'd7,        32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 0);
    run_op(3'd1, MIN_NEG,      MIN_NEG,       5'd2,  32'h4000_0000, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2,        5'd4,  32'hFFFF_FFFF, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,        5'd5,  32'hFFFF_FFFD, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,        5'd6,  32'hFFFF_FFFF, 0);
    run_op(3'd4, MIN_NEG,      32'hFFFF_FFFF, 5'd7,  32'h8000_0000, 0);
    run_op(3'd6, MIN_NEG,      32'hFFFF_FFFF, 5'd8,  32'h0000_0000, 0);
    run_op(3'd5, 32'd100,      32'd0,         5'd9,  32'hFFFF_FFFF, 0);
    run_op(3'd7, 32'd100,      32'd0,         5'd10, 32'd100,       0);
    run_op(3'd4, 32'd20,       32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFFA, 0);
    run_op(3'd6, 32'd20,       32'hFFFF_FFFD, 5'd12, 32'd2,         0);
    run_op(3'd5, 32'hFFFF_FFFF, 32'd10,       5'd13, 32'h1999_9999, 0);
    run_op(3'd7, 32'hFFFF_FFFF, 32'd10,       5'd14, 32'd5,         0);
    run_op(3'd6, 32'hFFFF_FFFB, 32'd0,        5'd15, 32'hFFFF_FFFB, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd3,        5'd16, 32'hFFFF_FFFF, 0);
    run_op(3'd3, 32'h8000_0000, 32'd4,        5'd17, 32'd2,         5);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd0,        5'd18, 32'hFFFF_FFFF, 5);

    // Flush ten cycles into a divide: nothing may ever be presented.
    issue(3'd5, 32'd1000, 32'd7, 5'd20);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    exp_q.delete();
    exp_tag_q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    repeat (40) begin @(posedge clk); #1; check("flush_no_valid", 32'(out_valid), 32'd0); end

    // Request presented together with flush in IDLE is dropped.
    flush = 1'b1; in_valid = 1'b1; funct3 = 3'd5; rs1 = 32'd9; rs2 = 32'd0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle_in_ready", 32'(in_ready), 32'd1);
    check("flush_idle_busy", 32'(busy), 32'd0);
    repeat (3) begin @(posedge clk); #1; check("flush_idle_no_valid", 32'(out_valid), 32'd0); end

    // Asynchronous reset mid-BUSY.
    issue(3'd4, 32'd1000, 32'd3, 5'd21);
    repeat (5) begin @(posedge clk); #1; end
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    exp_q.delete();
    exp_tag_q.delete();
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_tag", 32'(tag_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (40) begin @(posedge clk); #1; check("arst_no_valid", 32'(out_valid), 32'd0); end

    run_op(3'd0, 32'h0001_0003, 32'h0000_0005, 5'd22, 32'h0005_000F, 2);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_muldiv.md
Name: riscv_muldiv

Overview:
Multi-cycle RV32M/RV64M multiply-divide unit, parametrised in data width. It attaches beside the core's ALU as a long-latency execute unit. It is the next step from the single-cycle core, which has no M-extension: the core issues an operation over a valid/ready handshake, stalls while busy, and accepts the result over a second valid/ready handshake. Iterative shift-add multiplier and restoring divider, with fast paths for divide special cases.

Parameters:
DATA_W, 32, operand/result width; even, >= 8.
TAG_W, 5, width of destination-register tag carried alongside the operation.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  operation request.
in_ready  output  1  unit can accept (IDLE state).
funct3  input  3  RV M-op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
rs1  input  DATA_W  operand A.
rs2  input  DATA_W  operand B.
tag_in  input  TAG_W  destination tag.
flush  input  1  abort any in-flight operation.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
result  output  DATA_W  result.
tag_out  output  TAG_W  tag of the result.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset low): state IDLE; in_ready=1, out_valid=0, busy=0, result=0, tag_out=0; counter and accumulators cleared.
- FSM states: IDLE, BUSY, FIX, DONE.
- Accept: in_valid && in_ready at edge N latches funct3, rs1, rs2 and tag_in. in_ready is low in every state except IDLE.
- Normal path: edge N moves IDLE->BUSY. BUSY runs exactly DATA_W iterations, on edges N+1..N+DATA_W; the last of these moves to FIX. FIX applies sign correction and result selection; edge N+DATA_W+1 moves FIX->DONE with out_valid=1.
- Multiply: operands are converted to magnitudes per signedness (MULH both signed, MULHSU rs1 signed only, MULHU/MUL unsigned magnitude); the unit builds a 2*DATA_W-bit product and negates it in FIX when signs differ. MUL returns low DATA_W bits; the MULH* ops return high DATA_W bits.
- Divide: restoring algorithm on magnitudes (DIV/REM signed, DIVU/REMU unsigned). Quotient sign = sign(rs1) XOR sign(rs2). Remainder sign = sign(rs1).
- Special cases, detected at accept, go IDLE->DONE at edge N (out_valid after 1 cycle):
  - Divide by zero: DIV/DIVU returns all-ones; REM/REMU returns rs1.
  - Signed overflow (rs1 = most-negative, rs2 = all-ones, DIV/REM): DIV returns rs1; REM returns 0.
- DONE: out_valid, result and tag_out stay stable until out_ready=1. On that edge the unit goes to IDLE (in_ready=1 next cycle). No back-to-back accept on the same edge as output retire.
- Flush: synchronous and highest priority. Any state goes to IDLE at the next edge; out_valid drops and any pending result is discarded. If flush and in_valid are high together in IDLE, the request is not accepted.
- The unit takes no input while not in IDLE; operand changes then are ignored.

Optional Feature:
Macro RISCV_MULDIV_FAST_MUL_EN.
- Defined: multiply ops use a single combinational DATA_W x DATA_W multiplier. Accept at edge N moves to FIX; DONE at edge N+1 (2-cycle latency). Divides are unchanged.
- Not defined: multiply uses the iterative path with DATA_W+2 latency.

Decomposition:
- Package riscv_muldiv_pkg holds:
  - enum muldiv_op_e for the eight funct3 codes;
  - enum muldiv_state_e {IDLE, BUSY, FIX, DONE};
  - helper functions is_div(op), is_signed_a(op), is_signed_b(op).
- One sub-module, riscv_muldiv_div_step: one combinational restoring-divide iteration (shift partial remainder, trial subtract, quotient bit), instantiated once in BUSY.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) -> result 0xFFFFFFEB, out_valid 34 cycles after accept (2 cycles with RISCV_MULDIV_FAST_MUL_EN).
- MULH rs1=rs2=0x80000000 -> 0x40000000; MULHU rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV rs1=-7, rs2=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIV rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000 with out_valid 1 cycle after accept.
- DIVU rs1=100, rs2=0 -> 0xFFFFFFFF; REMU same operands -> 100; both retire after 1 cycle.
- Backpressure: out_ready held low 5 cycles after out_valid -> result and tag_out stable and in_ready=0 throughout; retire on first out_ready=1.
- Flush asserted at cycle 10 of a DIVU, then reset pulsed low mid-BUSY on a later op -> IDLE next edge, out_valid never asserted; reset forces all outputs to reset values immediately.
